// File: rtl/sync_clk_div_pkg.sv
// Shared types, reset defaults and helpers for the sync-aligned divided-clock generator.
package sync_clk_div_pkg;

    typedef enum logic [1:0] {
        CH_IDLE,
        CH_DELAY,
        CH_RUN
    } ch_state_e;

    localparam int CFG_DIV_W = 8;
    localparam int CFG_DLY_W = 12;

    // Default-width view of one channel's programmable settings.
    typedef struct packed {
        logic [CFG_DIV_W-1:0] half;
        logic [CFG_DLY_W-1:0] dly;
        logic                 en;
    } ch_cfg_t;

    localparam int   RST_HALF = 1;
    localparam int   RST_DLY  = 0;
    localparam logic RST_EN   = 1'b0;

    function automatic int chWidth(input int numCh);
        return (numCh > 1) ? $clog2(numCh) : 1;
    endfunction

endpackage

// File: rtl/sync_clk_div_if.sv
// Shadow-register write bus shared by the configuring master and the clock generator.
interface sync_clk_div_if
    import sync_clk_div_pkg::*;
#(
    parameter int NUM_CH = 2,
    parameter int DIV_W  = 8,
    parameter int DLY_W  = 12
);
    localparam int CH_W = chWidth(NUM_CH);

    logic             i_cfg_wr;
    logic [CH_W-1:0]  i_cfg_ch;
    logic [DIV_W-1:0] i_cfg_half;
    logic [DLY_W-1:0] i_cfg_dly;
    logic             i_cfg_en;

    modport master (
        output i_cfg_wr, i_cfg_ch, i_cfg_half, i_cfg_dly, i_cfg_en
    );

    modport slave (
        input i_cfg_wr, i_cfg_ch, i_cfg_half, i_cfg_dly, i_cfg_en
    );

endinterface

// File: rtl/sync_clk_div_ch.sv
// One output channel: active half-period, IDLE/DELAY/RUN sequencing and the registered
// divided clock with its rise and sync strobes.
module sync_clk_div_ch
    import sync_clk_div_pkg::*;
#(
    parameter int DIV_W = 8,
    parameter int DLY_W = 12
) (
    input  logic             sys_clk,
    input  logic             rst_n,
    input  logic             syncEvent_i,
    input  logic [DIV_W-1:0] half_i,
    input  logic [DLY_W-1:0] dly_i,
    input  logic             en_i,
    output logic             clk_o,
    output logic             rise_o,
    output logic             sync_o,
    output logic             running_o
);
    ch_state_e        state_q, state_d;
    logic [DIV_W-1:0] half_q, half_d;
    logic [DIV_W-1:0] phase_q, phase_d;
    logic [DLY_W-1:0] dlyCnt_q, dlyCnt_d;
    logic             clk_q, clk_d;
    logic             rise_q, rise_d;
    logic             sync_q, sync_d;
    logic             lastPhase;

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= CH_IDLE;
            half_q   <= DIV_W'(RST_HALF);
            phase_q  <= '0;
            dlyCnt_q <= DLY_W'(RST_DLY);
            clk_q    <= 1'b0;
            rise_q   <= 1'b0;
            sync_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            half_q   <= half_d;
            phase_q  <= phase_d;
            dlyCnt_q <= dlyCnt_d;
            clk_q    <= clk_d;
            rise_q   <= rise_d;
            sync_q   <= sync_d;
        end
    end

    // Half-periods of 0 and 1 both toggle every cycle.
    assign lastPhase = (half_q <= DIV_W'(1)) || (phase_q == half_q - DIV_W'(1));

    always_comb begin
        state_d  = state_q;
        half_d   = half_q;
        phase_d  = phase_q;
        dlyCnt_d = dlyCnt_q;
        clk_d    = clk_q;
        rise_d   = 1'b0;
        sync_d   = 1'b0;
        if (syncEvent_i) begin
            half_d  = half_i;
            phase_d = '0;
            clk_d   = 1'b0;
            if (!en_i) begin
                state_d = CH_IDLE;
            end else if (state_q == CH_RUN) begin
                // A running clock is pulled low for at least one cycle before restarting.
                state_d  = CH_DELAY;
                dlyCnt_d = dly_i;
            end else if (dly_i == '0) begin
                state_d = CH_RUN;
                clk_d   = 1'b1;
                rise_d  = 1'b1;
                sync_d  = 1'b1;
            end else begin
                state_d  = CH_DELAY;
                dlyCnt_d = dly_i - DLY_W'(1);
            end
        end else begin
            case (state_q)
                CH_IDLE: begin
                    clk_d = 1'b0;
                end
                CH_DELAY: begin
                    if (dlyCnt_q == '0) begin
                        state_d = CH_RUN;
                        phase_d = '0;
                        clk_d   = 1'b1;
                        rise_d  = 1'b1;
                        sync_d  = 1'b1;
                    end else begin
                        dlyCnt_d = dlyCnt_q - DLY_W'(1);
                    end
                end
                CH_RUN: begin
                    if (lastPhase) begin
                        phase_d = '0;
                        clk_d   = ~clk_q;
                        rise_d  = ~clk_q;
                    end else begin
                        phase_d = phase_q + DIV_W'(1);
                    end
                end
                default: begin
                    state_d = CH_IDLE;
                    clk_d   = 1'b0;
                end
            endcase
        end
    end

    assign clk_o     = clk_q;
    assign rise_o    = rise_q;
    assign sync_o    = sync_q;
    assign running_o = (state_q == CH_RUN);

endmodule

// File: rtl/sync_clk_div.sv
// Multi-channel divided-clock generator: sync synchronizer and edge detect, per-channel
// shadow registers with write decode, and one sequencing channel per output clock.
module sync_clk_div
    import sync_clk_div_pkg::*;
#(
    parameter int NUM_CH      = 2,
    parameter int DIV_W       = 8,
    parameter int DLY_W       = 12,
    parameter int SYNC_STAGES = 0
) (
    input  logic              sys_clk,
    input  logic              rst_n,
    input  logic              i_sync,
    sync_clk_div_if.slave     cfg,
    output logic [NUM_CH-1:0] o_clk,
    output logic [NUM_CH-1:0] o_rise,
    output logic [NUM_CH-1:0] o_sync,
    output logic [NUM_CH-1:0] o_running
);
    localparam int CH_W = chWidth(NUM_CH);

    logic             syncLvl;
    logic             syncPrev_q;
    logic             syncEvent;
    logic [DIV_W-1:0] shadowHalf_q [NUM_CH];
    logic [DIV_W-1:0] shadowHalf_d [NUM_CH];
    logic [DLY_W-1:0] shadowDly_q  [NUM_CH];
    logic [DLY_W-1:0] shadowDly_d  [NUM_CH];
    logic             shadowEn_q   [NUM_CH];
    logic             shadowEn_d   [NUM_CH];

    if (SYNC_STAGES == 0) begin : g_directSync
        assign syncLvl = i_sync;
    end else begin : g_syncChain
        logic [SYNC_STAGES-1:0] chain_q;
        always_ff @(posedge sys_clk or negedge rst_n) begin
            if (!rst_n) begin
                chain_q <= '0;
            end else begin
                chain_q[0] <= i_sync;
                for (int s = 1; s < SYNC_STAGES; s++) begin
                    chain_q[s] <= chain_q[s-1];
                end
            end
        end
        assign syncLvl = chain_q[SYNC_STAGES-1];
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            syncPrev_q <= 1'b0;
            for (int c = 0; c < NUM_CH; c++) begin
                shadowHalf_q[c] <= DIV_W'(RST_HALF);
                shadowDly_q[c]  <= DLY_W'(RST_DLY);
                shadowEn_q[c]   <= RST_EN;
            end
        end else begin
            syncPrev_q   <= syncLvl;
            shadowHalf_q <= shadowHalf_d;
            shadowDly_q  <= shadowDly_d;
            shadowEn_q   <= shadowEn_d;
        end
    end

    assign syncEvent = syncLvl && !syncPrev_q;

    // The shadow next-state doubles as the value loaded at an event, giving write-through.
    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic wrSel;
        assign wrSel           = cfg.i_cfg_wr && (cfg.i_cfg_ch == CH_W'(c));
        assign shadowHalf_d[c] = wrSel ? cfg.i_cfg_half : shadowHalf_q[c];
        assign shadowDly_d[c]  = wrSel ? cfg.i_cfg_dly  : shadowDly_q[c];
        assign shadowEn_d[c]   = wrSel ? cfg.i_cfg_en   : shadowEn_q[c];

        sync_clk_div_ch #(
            .DIV_W (DIV_W),
            .DLY_W (DLY_W)
        ) u_ch (
            .sys_clk     (sys_clk),
            .rst_n       (rst_n),
            .syncEvent_i (syncEvent),
            .half_i      (shadowHalf_d[c]),
            .dly_i       (shadowDly_d[c]),
            .en_i        (shadowEn_d[c]),
            .clk_o       (o_clk[c]),
            .rise_o      (o_rise[c]),
            .sync_o      (o_sync[c]),
            .running_o   (o_running[c])
        );
    end

endmodule

// File: tb/tb_sync_clk_div.sv
// Directed bench for sync_clk_div: one directly-synced instance and one with a 2-flop sync chain.
module tb_sync_clk_div;

    logic       sys_clk = 1'b0;
    logic       rst_n;
    logic       syncA, syncB;
    logic [1:0] clkA, riseA, syncOA, runA;
    logic [1:0] clkB, riseB, syncOB, runB;
    int         checks = 0;
    int         errors = 0;

    sync_clk_div_if #(.NUM_CH(2), .DIV_W(8), .DLY_W(12)) cfgA ();
    sync_clk_div_if #(.NUM_CH(2), .DIV_W(8), .DLY_W(12)) cfgB ();

    sync_clk_div #(.NUM_CH(2), .DIV_W(8), .DLY_W(12), .SYNC_STAGES(0)) dutA (
        .sys_clk   (sys_clk),
        .rst_n     (rst_n),
        .i_sync    (syncA),
        .cfg       (cfgA),
        .o_clk     (clkA),
        .o_rise    (riseA),
        .o_sync    (syncOA),
        .o_running (runA)
    );

    sync_clk_div #(.NUM_CH(2), .DIV_W(8), .DLY_W(12), .SYNC_STAGES(2)) dutB (
        .sys_clk   (sys_clk),
        .rst_n     (rst_n),
        .i_sync    (syncB),
        .cfg       (cfgB),
        .o_clk     (clkB),
        .o_rise    (riseB),
        .o_sync    (syncOB),
        .o_running (runB)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic applyStimulus(input int ch, input int half, input int dly, input logic en);
        cfgA.i_cfg_wr   = 1'b1;
        cfgA.i_cfg_ch   = 1'(ch);
        cfgA.i_cfg_half = 8'(half);
        cfgA.i_cfg_dly  = 12'(dly);
        cfgA.i_cfg_en   = en;
        step();
        cfgA.i_cfg_wr   = 1'b0;
    endtask

    // The cycle with syncA high is the event cycle E; returns positioned in cycle E+1.
    task automatic pulseSyncA();
        syncA = 1'b1;
        step();
        syncA = 1'b0;
    endtask

    task automatic test_reset();
        logic [15:0] obs;
        rst_n = 1'b0;
        syncA = 1'b0;
        syncB = 1'b0;
        cfgA.i_cfg_wr = 1'b0; cfgA.i_cfg_ch = '0; cfgA.i_cfg_half = '0; cfgA.i_cfg_dly = '0; cfgA.i_cfg_en = 1'b0;
        cfgB.i_cfg_wr = 1'b0; cfgB.i_cfg_ch = '0; cfgB.i_cfg_half = '0; cfgB.i_cfg_dly = '0; cfgB.i_cfg_en = 1'b0;
        repeat (3) step();
        obs = {clkA, riseA, syncOA, runA, clkB, riseB, syncOB, runB};
        checks++;
        if (obs !== 16'h0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got %h expected 0000", obs);
        end
        rst_n = 1'b1;
        applyStimulus(0, 3, 0, 1'b1);
        applyStimulus(1, 2, 1, 1'b1);
        for (int i = 0; i < 200; i++) begin
            obs = {clkA, riseA, syncOA, runA, clkB, riseB, syncOB, runB};
            checks++;
            if (obs !== 16'h0) begin
                errors++;
                $display("[TB] FAIL idle_no_sync cyc %0d: got %h expected 0000", i, obs);
            end
            step();
        end
    endtask

    task automatic test_basic();
        logic [3:0] exp0;
        applyStimulus(0, 3, 0, 1'b1);
        applyStimulus(1, 1, 0, 1'b0);
        pulseSyncA();
        for (int i = 0; i < 13; i++) begin
            exp0 = {((i / 3) % 2) == 0, (i % 6) == 0, i == 0, 1'b1};
            checks++;
            if ({clkA[0], riseA[0], syncOA[0], runA[0]} !== exp0) begin
                errors++;
                $display("[TB] FAIL basic_ch0 E+%0d: clk/rise/sync/run got %b expected %b",
                         i + 1, {clkA[0], riseA[0], syncOA[0], runA[0]}, exp0);
            end
            checks++;
            if ({clkA[1], riseA[1], syncOA[1], runA[1]} !== 4'b0000) begin
                errors++;
                $display("[TB] FAIL basic_ch1_idle E+%0d: got %b expected 0000",
                         i + 1, {clkA[1], riseA[1], syncOA[1], runA[1]});
            end
            step();
        end
    endtask

    task automatic test_independent();
        logic [3:0] exp0, exp1;
        int         k;
        applyStimulus(0, 3, 0, 1'b0);
        applyStimulus(1, 0, 5, 1'b0);
        pulseSyncA();
        checks++;
        if (runA !== 2'b00) begin
            errors++;
            $display("[TB] FAIL indep_idle_first: running got %b expected 00", runA);
        end
        applyStimulus(0, 3, 0, 1'b1);
        applyStimulus(1, 0, 5, 1'b1);
        pulseSyncA();
        for (int i = 0; i < 14; i++) begin
            k    = i - 5;
            exp0 = {((i / 3) % 2) == 0, (i % 6) == 0, i == 0, 1'b1};
            exp1 = {(i >= 5) && ((k % 2) == 0), (i >= 5) && ((k % 2) == 0), i == 5, i >= 5};
            checks++;
            if ({clkA[0], riseA[0], syncOA[0], runA[0]} !== exp0) begin
                errors++;
                $display("[TB] FAIL indep_ch0 E+%0d: got %b expected %b",
                         i + 1, {clkA[0], riseA[0], syncOA[0], runA[0]}, exp0);
            end
            checks++;
            if ({clkA[1], riseA[1], syncOA[1], runA[1]} !== exp1) begin
                errors++;
                $display("[TB] FAIL indep_ch1 E+%0d: got %b expected %b",
                         i + 1, {clkA[1], riseA[1], syncOA[1], runA[1]}, exp1);
            end
            step();
        end
    endtask

    task automatic test_reprogram();
        logic [3:0] exp0;
        int         j;
        applyStimulus(1, 1, 0, 1'b0);
        applyStimulus(0, 3, 0, 1'b1);
        pulseSyncA();
        for (int i = 0; i < 15; i++) begin
            j    = i - 1;
            exp0 = (i == 0) ? 4'b0000 : {((j / 3) % 2) == 0, (j % 6) == 0, j == 0, 1'b1};
            checks++;
            if ({clkA[0], riseA[0], syncOA[0], runA[0]} !== exp0) begin
                errors++;
                $display("[TB] FAIL restart_half3 E+%0d: got %b expected %b",
                         i + 1, {clkA[0], riseA[0], syncOA[0], runA[0]}, exp0);
            end
            checks++;
            if ({clkA[1], riseA[1], syncOA[1], runA[1]} !== 4'b0000) begin
                errors++;
                $display("[TB] FAIL ch1_disabled E+%0d: got %b expected 0000",
                         i + 1, {clkA[1], riseA[1], syncOA[1], runA[1]});
            end
            if (i == 4) applyStimulus(0, 5, 0, 1'b1);
            else step();
        end
        pulseSyncA();
        for (int i = 0; i < 22; i++) begin
            j    = i - 1;
            exp0 = (i == 0) ? 4'b0000 : {((j / 5) % 2) == 0, (j % 10) == 0, j == 0, 1'b1};
            checks++;
            if ({clkA[0], riseA[0], syncOA[0], runA[0]} !== exp0) begin
                errors++;
                $display("[TB] FAIL reprog_half5 E+%0d: got %b expected %b",
                         i + 1, {clkA[0], riseA[0], syncOA[0], runA[0]}, exp0);
            end
            step();
        end
    endtask

    task automatic test_delay_restart();
        logic [3:0] exp0;
        int         k;
        cfgA.i_cfg_wr   = 1'b1;
        cfgA.i_cfg_ch   = 1'b0;
        cfgA.i_cfg_half = 8'd2;
        cfgA.i_cfg_dly  = 12'd10;
        cfgA.i_cfg_en   = 1'b1;
        pulseSyncA();
        cfgA.i_cfg_wr   = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({clkA[0], riseA[0], syncOA[0], runA[0]} !== 4'b0000) begin
                errors++;
                $display("[TB] FAIL delay_first E+%0d: got %b expected 0000",
                         i + 1, {clkA[0], riseA[0], syncOA[0], runA[0]});
            end
            step();
        end
        pulseSyncA();
        for (int i = 0; i < 15; i++) begin
            k    = i - 10;
            exp0 = {(i >= 10) && (((k / 2) % 2) == 0), (i >= 10) && ((k % 4) == 0), i == 10, i >= 10};
            checks++;
            if ({clkA[0], riseA[0], syncOA[0], runA[0]} !== exp0) begin
                errors++;
                $display("[TB] FAIL delay_restart E2+%0d: got %b expected %b",
                         i + 1, {clkA[0], riseA[0], syncOA[0], runA[0]}, exp0);
            end
            step();
        end
    endtask

    task automatic test_disable();
        checks++;
        if (runA[0] !== 1'b1) begin
            errors++;
            $display("[TB] FAIL disable_precond: running got %b expected 1", runA[0]);
        end
        applyStimulus(0, 2, 10, 1'b0);
        pulseSyncA();
        for (int i = 0; i < 10; i++) begin
            checks++;
            if ({clkA[0], riseA[0], syncOA[0], runA[0]} !== 4'b0000) begin
                errors++;
                $display("[TB] FAIL disable E+%0d: got %b expected 0000",
                         i + 1, {clkA[0], riseA[0], syncOA[0], runA[0]});
            end
            step();
        end
    endtask

    task automatic test_reset_midrun();
        applyStimulus(0, 3, 0, 1'b1);
        pulseSyncA();
        step();
        checks++;
        if ({clkA[0], runA[0]} !== 2'b11) begin
            errors++;
            $display("[TB] FAIL midrun_precond: clk/run got %b expected 11", {clkA[0], runA[0]});
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({clkA, riseA, syncOA, runA} !== 8'h00) begin
            errors++;
            $display("[TB] FAIL async_reset: got %h expected 00", {clkA, riseA, syncOA, runA});
        end
        repeat (2) step();
        rst_n = 1'b1;
        applyStimulus(0, 3, 0, 1'b1);
        for (int i = 0; i < 30; i++) begin
            checks++;
            if ({clkA, riseA, syncOA, runA} !== 8'h00) begin
                errors++;
                $display("[TB] FAIL post_reset_idle cyc %0d: got %h expected 00", i, {clkA, riseA, syncOA, runA});
            end
            step();
        end
        pulseSyncA();
        checks++;
        if ({clkA[0], riseA[0], syncOA[0], runA[0]} !== 4'b1111) begin
            errors++;
            $display("[TB] FAIL post_reset_sync E+1: got %b expected 1111",
                     {clkA[0], riseA[0], syncOA[0], runA[0]});
        end
    endtask

    task automatic test_sync_stages();
        logic [3:0] exp0;
        int         k;
        cfgB.i_cfg_wr   = 1'b1;
        cfgB.i_cfg_ch   = 1'b0;
        cfgB.i_cfg_half = 8'd3;
        cfgB.i_cfg_dly  = 12'd0;
        cfgB.i_cfg_en   = 1'b1;
        step();
        cfgB.i_cfg_wr   = 1'b0;
        syncB = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            step();
            k    = i - 3;
            exp0 = {(i >= 3) && (((k / 3) % 2) == 0), (i >= 3) && ((k % 6) == 0), i == 3, i >= 3};
            checks++;
            if ({clkB[0], riseB[0], syncOB[0], runB[0]} !== exp0) begin
                errors++;
                $display("[TB] FAIL sync_stages2 S+%0d: got %b expected %b",
                         i, {clkB[0], riseB[0], syncOB[0], runB[0]}, exp0);
            end
        end
        syncB = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_independent();
        test_reprogram();
        test_delay_restart();
        test_disable();
        test_reset_midrun();
        test_sync_stages();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
